// File: rtl/ssd_scan_mux.sv
// ssd_scan_mux: time-multiplexed scan driver for a bank of 7-segment digits.
// Feeds one nibble per slot to a downstream hex-to-segment decoder and drives the
// matching digit enable. A double-buffered display value keeps host updates from
// tearing mid-frame.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   value_i    - packed nibbles, nibble k shown on digit k (digit 0 rightmost)
//   load_i     - one-cycle strobe capturing value_i, digit_en_i, dp_i
//   digit_en_i - per-digit enable (0 blanks the digit)
//   dp_i       - per-digit decimal point request
//   hex_o      - nibble for the current slot
//   an_o       - one-hot digit enable, polarity set by AN_ACTIVE_LOW
//   dp_o       - decimal point for the current slot, active-high
//   frame_o    - one-cycle pulse coincident with the slot-0 output update
//   pending_o  - a captured update is waiting for the next frame boundary
//
// Optional build macro SSD_LEADING_ZERO_BLANK_EN: when defined, digits above the
// most-significant nonzero nibble are also blanked (digit 0 always allowed).
module ssd_scan_mux #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned REFRESH_DIV   = 100000,
  parameter bit          AN_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic                    load_i,
  input  logic [NUM_DIGITS-1:0]   digit_en_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  output logic [3:0]              hex_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    dp_o,
  output logic                    frame_o,
  output logic                    pending_o
);

  localparam int unsigned CntW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned SlotW = $clog2(NUM_DIGITS);
  localparam int unsigned ValW  = 4 * NUM_DIGITS;
  localparam logic [NUM_DIGITS-1:0] AnOff = AN_ACTIVE_LOW ? '1 : '0;

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [SlotW-1:0]      slot_q, slot_d;
  logic [ValW-1:0]       pend_val_q, pend_val_d, disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0] pend_en_q, pend_en_d, disp_en_q, disp_en_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic                  pend_q, pend_d;
  logic [3:0]            hex_q, hex_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  dp_q, dp_d;
  logic                  frame_q, frame_d;

  logic                  tick;
  logic                  boundary;
  logic [NUM_DIGITS-1:0] lit_mask;
  logic [NUM_DIGITS-1:0] onehot;

  // Prescaler and slot counter.
  always_comb begin
    tick     = (cnt_q == CntW'(REFRESH_DIV - 1));
    boundary = tick && (slot_q == SlotW'(NUM_DIGITS - 1));
    cnt_d    = tick ? '0 : cnt_q + CntW'(1);
    slot_d   = slot_q;
    if (tick) begin
      slot_d = boundary ? '0 : slot_q + SlotW'(1);
    end
  end

  // Double buffer. A load on the boundary cycle bypasses straight into display.
  always_comb begin
    pend_val_d = pend_val_q;
    pend_en_d  = pend_en_q;
    pend_dp_d  = pend_dp_q;
    pend_d     = pend_q;
    disp_val_d = disp_val_q;
    disp_en_d  = disp_en_q;
    disp_dp_d  = disp_dp_q;
    if (boundary) begin
      if (load_i) begin
        disp_val_d = value_i;
        disp_en_d  = digit_en_i;
        disp_dp_d  = dp_i;
      end else if (pend_q) begin
        disp_val_d = pend_val_q;
        disp_en_d  = pend_en_q;
        disp_dp_d  = pend_dp_q;
      end
      pend_d = 1'b0;
    end else if (load_i) begin
      pend_val_d = value_i;
      pend_en_d  = digit_en_i;
      pend_dp_d  = dp_i;
      pend_d     = 1'b1;
    end
  end

`ifdef SSD_LEADING_ZERO_BLANK_EN
  // Scan from the top digit down; a digit may light once any nibble at or
  // above it is nonzero. Digit 0 is always allowed.
  always_comb begin
    logic seen;
    seen     = 1'b0;
    lit_mask = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      seen        = seen | (disp_val_d[4*k +: 4] != 4'h0);
      lit_mask[k] = seen || (k == 0);
    end
  end
`else
  always_comb begin
    lit_mask = '1;
  end
`endif

  // Outputs are computed from the next slot and next display so every output
  // changes on the same edge, and a boundary bypass is visible in slot 0.
  always_comb begin
    hex_d   = hex_q;
    an_d    = an_q;
    dp_d    = dp_q;
    frame_d = boundary;
    onehot  = '0;
    if (tick) begin
      hex_d = 4'h0;
      dp_d  = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (slot_d == SlotW'(k)) begin
          hex_d     = disp_val_d[4*k +: 4];
          dp_d      = disp_dp_d[k];
          onehot[k] = disp_en_d[k] & lit_mask[k];
        end
      end
      an_d = AN_ACTIVE_LOW ? ~onehot : onehot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      slot_q     <= '0;
      pend_val_q <= '0;
      pend_en_q  <= '0;
      pend_dp_q  <= '0;
      pend_q     <= 1'b0;
      disp_val_q <= '0;
      disp_en_q  <= '0;
      disp_dp_q  <= '0;
      hex_q      <= 4'h0;
      an_q       <= AnOff;
      dp_q       <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      pend_val_q <= pend_val_d;
      pend_en_q  <= pend_en_d;
      pend_dp_q  <= pend_dp_d;
      pend_q     <= pend_d;
      disp_val_q <= disp_val_d;
      disp_en_q  <= disp_en_d;
      disp_dp_q  <= disp_dp_d;
      hex_q      <= hex_d;
      an_q       <= an_d;
      dp_q       <= dp_d;
      frame_q    <= frame_d;
    end
  end

  assign hex_o     = hex_q;
  assign an_o      = an_q;
  assign dp_o      = dp_q;
  assign frame_o   = frame_q;
  assign pending_o = pend_q;

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Self-checking bench for ssd_scan_mux (NUM_DIGITS=4, REFRESH_DIV=4, active-low
// anodes). The reference model tracks elapsed cycles since reset and derives slot,
// tick and frame boundary arithmetically; the display buffer is plain variables.
module tb_ssd_scan_mux;

  localparam int N = 4;
  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value_i = '0;
  logic        load_i = 1'b0;
  logic [3:0]  digit_en_i = '0;
  logic [3:0]  dp_i = '0;
  logic [3:0]  hex_o;
  logic [3:0]  an_o;
  logic        dp_o;
  logic        frame_o;
  logic        pending_o;

  int checks = 0;
  int failures = 0;

  ssd_scan_mux #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (R),
    .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value_i   (value_i),
    .load_i    (load_i),
    .digit_en_i(digit_en_i),
    .dp_i      (dp_i),
    .hex_o     (hex_o),
    .an_o      (an_o),
    .dp_o      (dp_o),
    .frame_o   (frame_o),
    .pending_o (pending_o)
  );

  always #5 clk = ~clk;

  // Reference model state.
  int          cyc;
  logic [15:0] m_pval, m_dval;
  logic [3:0]  m_pen, m_pdp, m_den, m_ddp;
  bit          m_pend;
  logic [3:0]  e_hex, e_an;
  bit          e_dp, e_frame;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    cyc    = 0;
    m_pval = '0; m_pen = '0; m_pdp = '0; m_pend = 1'b0;
    m_dval = '0; m_den = '0; m_ddp = '0;
    e_hex  = '0; e_an = 4'hF; e_dp = 1'b0; e_frame = 1'b0;
  endtask

  function automatic bit lz_ok(input int k);
`ifdef SSD_LEADING_ZERO_BLANK_EN
    return (k == 0) || ((m_dval >> (4 * k)) != 16'h0);
`else
    return 1'b1;
`endif
  endfunction

  // Effect of the coming rising edge, given the inputs currently driven.
  task automatic model_edge();
    bit tick, bnd;
    int slot, nslot;
    tick = (cyc % R) == (R - 1);
    slot = (cyc / R) % N;
    bnd  = tick && (slot == N - 1);
    if (bnd) begin
      if (load_i) begin
        m_dval = value_i; m_den = digit_en_i; m_ddp = dp_i;
      end else if (m_pend) begin
        m_dval = m_pval; m_den = m_pen; m_ddp = m_pdp;
      end
      m_pend = 1'b0;
    end else if (load_i) begin
      m_pval = value_i; m_pen = digit_en_i; m_pdp = dp_i;
      m_pend = 1'b1;
    end
    if (tick) begin
      nslot = ((cyc + 1) / R) % N;
      e_hex = m_dval[4*nslot +: 4];
      e_dp  = m_ddp[nslot];
      e_an  = (m_den[nslot] && lz_ok(nslot)) ? ~(4'b0001 << nslot) : 4'hF;
    end
    e_frame = bnd;
    cyc++;
  endtask

  task automatic compare_all();
    check_eq("hex_o", {28'h0, hex_o}, {28'h0, e_hex});
    check_eq("an_o", {28'h0, an_o}, {28'h0, e_an});
    check_eq("dp_o", {31'h0, dp_o}, {31'h0, e_dp});
    check_eq("frame_o", {31'h0, frame_o}, {31'h0, e_frame});
    check_eq("pending_o", {31'h0, pending_o}, {31'h0, m_pend});
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_hex"}, {28'h0, hex_o}, 32'h0);
    check_eq({tag, "_an"}, {28'h0, an_o}, 32'hF);
    check_eq({tag, "_dp"}, {31'h0, dp_o}, 32'h0);
    check_eq({tag, "_frame"}, {31'h0, frame_o}, 32'h0);
    check_eq({tag, "_pending"}, {31'h0, pending_o}, 32'h0);
  endtask

  task automatic cycle(input bit ld, input logic [15:0] v, input logic [3:0] en,
                       input logic [3:0] dp);
    load_i     = ld;
    value_i    = v;
    digit_en_i = en;
    dp_i       = dp;
    model_edge();
    @(posedge clk);
    #1;
    load_i = 1'b0;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 4'h0, 4'h0);
  endtask

  // Advance until the next edge will be at the given position within the frame.
  task automatic idle_until(input int phase);
    while ((cyc % (N * R)) != phase) cycle(1'b0, 16'h0, 4'h0, 4'h0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    #12;
    check_reset_outputs("reset");
    release_reset();

    // Idle: anodes stay off, frame pulses every N*R cycles.
    idle(40);

    // Basic load, away from a boundary.
    idle_until(3);
    cycle(1'b1, 16'h12AF, 4'hF, 4'h0);
    check_eq("pending_after_load", {31'h0, pending_o}, 32'h1);
    idle(40);

    // Two loads in one frame: last writer wins.
    idle_until(2);
    cycle(1'b1, 16'h1111, 4'hF, 4'h0);
    idle(2);
    cycle(1'b1, 16'h2222, 4'hF, 4'h0);
    idle(40);

    // Load coincident with the frame boundary bypasses into display.
    idle_until(N * R - 1);
    cycle(1'b1, 16'hBEEF, 4'hF, 4'h0);
    check_eq("bypass_pending", {31'h0, pending_o}, 32'h0);
    check_eq("bypass_hex", {28'h0, hex_o}, 32'hF);
    idle(20);

    // Blanked digits and decimal points.
    idle_until(5);
    cycle(1'b1, 16'h5678, 4'b0101, 4'b0100);
    idle(40);

`ifdef SSD_LEADING_ZERO_BLANK_EN
    idle_until(5);
    cycle(1'b1, 16'h0030, 4'hF, 4'h0);
    idle(36);
    idle_until(5);
    cycle(1'b1, 16'h0000, 4'hF, 4'h0);
    idle(36);
`endif

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom), 4'($urandom));
    end

    // Asynchronous reset in slot 2 with an update pending.
    idle_until(6);
    cycle(1'b1, 16'h9A5C, 4'hF, 4'hF);
    idle_until(9);
    check_eq("pending_before_rst", {31'h0, pending_o}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    check_reset_outputs("held_rst");
    release_reset();
    idle(20);

    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 5) == 0), 16'($urandom), 4'($urandom), 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ssd_scan_mux.md
Name: ssd_scan_mux

Overview:
- Time-multiplexed scan driver for a bank of common-anode/common-cathode 7-segment digits.
- Sits directly upstream of the hex-to-segment decoder (SSD). Drives one 4-bit nibble per slot into the decoder and the matching digit enable to the board.
- Holds a double-buffered display value so that a host update never tears mid-frame.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits (2..8).
- REFRESH_DIV, 100000: clk cycles per digit slot (>=1).
- AN_ACTIVE_LOW, 1: 1 means the anode output asserts as 0; 0 means it asserts as 1.

Ports:
- clk  in  1  system clock; all state is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- value_i  in  4*NUM_DIGITS  packed nibbles; nibble k (bits 4k+3:4k) is shown on digit k, with digit 0 the rightmost.
- load_i  in  1  one-cycle strobe that captures value_i, digit_en_i and dp_i.
- digit_en_i  in  NUM_DIGITS  per-digit enable; 0 blanks that digit.
- dp_i  in  NUM_DIGITS  per-digit decimal point request.
- hex_o  out  4  nibble for the current slot; feeds the SSD hex input.
- an_o  out  NUM_DIGITS  digit enables, one-hot asserted, polarity set by AN_ACTIVE_LOW.
- dp_o  out  1  decimal point for the current slot, active-high.
- frame_o  out  1  one-cycle pulse on each frame boundary (last slot wrapping to slot 0).
- pending_o  out  1  high while a captured update waits for the next frame boundary.

Behaviour:
- Reset state (asynchronous, while rst_n=0):
  - prescaler=0, slot=0.
  - pending and display registers = 0, pending flag = 0.
  - hex_o=0, dp_o=0, frame_o=0, pending_o=0.
  - an_o all deasserted: all ones if AN_ACTIVE_LOW=1, all zeros otherwise.
- Reset release: the first slot advance occurs REFRESH_DIV cycles after reset release. Until then an_o stays deasserted.
- Prescaler:
  - Counts 0..REFRESH_DIV-1.
  - tick is asserted when count = REFRESH_DIV-1; the counter then wraps to 0.
  - With REFRESH_DIV=1, tick is asserted every cycle.
- Slot counter:
  - Advances on tick: 0,1,...,NUM_DIGITS-1,0.
  - A wrap from NUM_DIGITS-1 to 0 is a frame boundary.
- Double buffer:
  - load_i copies value_i, digit_en_i and dp_i into the pending registers and sets the pending flag.
  - A later load_i before the boundary overwrites the pending registers (last writer wins).
  - On a frame boundary with the pending flag set, pending is copied to display and the flag clears.
  - load_i in the same cycle as a frame boundary: the new input bypasses directly into display and the flag stays/clears to 0.
  - pending_o is the registered pending flag.
- Outputs, registered, updated on the cycle after tick and all in the same edge (no ghosting):
  - hex_o = display nibble[slot].
  - dp_o = display dp[slot].
  - an_o asserts only bit[slot], and only if display digit_en[slot]=1; otherwise an_o is all deasserted.
  - hex_o and dp_o are driven even when the digit is blanked.
- frame_o: registered, high for exactly the one cycle coincident with the slot-0 output update.
- Latency:
  - load_i to visible output: at most one frame (NUM_DIGITS*REFRESH_DIV cycles) plus 1.
  - tick to output change: 1 cycle.
- Reset mid-frame: all state returns to the reset state immediately. The pending update is discarded and the scan restarts at slot 0.

Optional Feature:
- Macro: SSD_LEADING_ZERO_BLANK_EN.
- When defined:
  - Digits above the most-significant nonzero nibble of display are additionally blanked, i.e. an_o is deasserted for them.
  - Digit 0 is never blanked by this rule.
  - If display value = 0, only digit 0 lights.
  - The rule is ANDed with digit_en.
- When undefined: only digit_en controls blanking, and leading zeros are shown.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, AN_ACTIVE_LOW=1 unless noted):
- Reset, then no load -> an_o=4'b1111 and hex_o=0 until the first tick. Afterwards an_o stays 1111 because display digit_en=0; frame_o pulses every 16 cycles.
- load value_i=16'h12AF, digit_en_i=4'hF, dp_i=0 -> pending_o=1 until the boundary. Then the slots show hex_o 0xF/0xA/0x2/0x1 with an_o 1110/1101/1011/0111, each held for 4 cycles.
- Two loads in one frame (16'h1111, then 16'h2222) -> only 2222 is displayed after the boundary; 1111 never appears on hex_o.
- load_i asserted on a frame-boundary cycle with 16'hBEEF -> slot 0 shows hex_o=0xF in the same frame and pending_o stays 0.
- digit_en_i=4'b0101, dp_i=4'b0100 -> an_o=1111 during slots 1 and 3; dp_o=1 only in slot 2.
- SSD_LEADING_ZERO_BLANK_EN defined:
  - value 16'h0030 -> slots 2 and 3 blanked, digits 1 and 0 lit.
  - value 16'h0000 -> only slot 0 lit with hex_o=0.
- Assert rst_n=0 asynchronously mid-slot 2 with an update pending -> outputs return to reset values within the same cycle and pending_o=0.
